// File: rtl/stn_scan_ctrl.sv
// stn_scan_ctrl -- scan-timing controller for the passive-matrix (STN) panel.
//
// Pulls BUS_WIDTH-pixel grey words (5 bits per pixel) from the frame fetch
// stream and presents them to BUS_WIDTH external dither LUT lanes. It then
// captures the 1-bit LUT results onto the panel data bus. It also generates
// the panel strobes CP/LP/FLM and the LUT frame-advance clock.
//
// Optional build macro: MONO_BYPASS_EN adds a `mono` input. When mono=1, the
// MSB of each grey value is used as a threshold instead of the LUT result,
// and lut_flm is held low.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   en              scan enable; sampled at frame start and at the end of HB
//   pix_valid/ready fetch-stream handshake (pix_ready is the only
//                   combinational output; every other output is a flop)
//   pix_sof         word is the first word of a frame
//   pix_data        grey words; [4:0] is the leftmost pixel
//   lut_raw         registered grey values to the LUT lanes
//   lut_flm         one-cycle pulse at frame start; steps the LUT patterns
//   dither_in       LUT results; bit i belongs to lut_raw[5i+4:5i]
//   lcd_d           panel data; [BUS_WIDTH-1] is the leftmost pixel
//   lcd_cp/lp/flm   shift clock, line latch, first-line marker
//   underrun        sticky: stall caused by a missing word mid-frame
//   sync_err        sticky: pix_sof seen anywhere but line 0 word 0
module stn_scan_ctrl #(
    parameter int H_PIXELS  = 320,
    parameter int V_LINES   = 240,
    parameter int BUS_WIDTH = 4,
    parameter int LP_CYCLES = 2,
    parameter int HB_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic                   pix_sof,
    input  logic [5*BUS_WIDTH-1:0] pix_data,
    output logic [5*BUS_WIDTH-1:0] lut_raw,
    output logic                   lut_flm,
    input  logic [BUS_WIDTH-1:0]   dither_in,
`ifdef MONO_BYPASS_EN
    input  logic                   mono,
`endif
    output logic [BUS_WIDTH-1:0]   lcd_d,
    output logic                   lcd_cp,
    output logic                   lcd_lp,
    output logic                   lcd_flm,
    output logic                   underrun,
    output logic                   sync_err
);
    localparam int WORDS = H_PIXELS / BUS_WIDTH;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW    = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int TMAX  = (LP_CYCLES > HB_CYCLES) ? LP_CYCLES : HB_CYCLES;
    localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
    localparam logic [TW-1:0] LP_LAST   = TW'(LP_CYCLES - 1);
    localparam logic [TW-1:0] HB_LAST   = TW'(HB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FSTART, FETCH, SHIFT, TAIL, LP, HB
    } state_e;

    state_e                 state_q, state_d;
    logic [WW-1:0]          word_q, word_d;
    logic [LW-1:0]          line_q, line_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [5*BUS_WIDTH-1:0] lut_raw_q, lut_raw_d;
    logic                   lut_flm_q, lut_flm_d;
    logic [BUS_WIDTH-1:0]   lcd_d_q, lcd_d_d;
    logic                   lcd_cp_q, lcd_cp_d;
    logic                   lcd_lp_q, lcd_lp_d;
    logic                   lcd_flm_q, lcd_flm_d;
    logic                   underrun_q, underrun_d;
    logic                   sync_err_q, sync_err_d;

    logic [BUS_WIDTH-1:0]   shift_bits;
    logic                   flm_step;

    // Lane i carries pixel i counted from the left, and the panel wants the
    // leftmost pixel on the MSB, so the lanes are bit-reversed onto lcd_d.
    always_comb begin
        shift_bits = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
`ifdef MONO_BYPASS_EN
            shift_bits[BUS_WIDTH-1-i] = mono ? lut_raw_q[5*i+4] : dither_in[i];
`else
            shift_bits[BUS_WIDTH-1-i] = dither_in[i];
`endif
        end
    end

`ifdef MONO_BYPASS_EN
    assign flm_step = ~mono;
`else
    assign flm_step = 1'b1;
`endif

    // In FSTART, non-sof words are drained. The sof word is held back and is
    // consumed by FETCH as pixel data.
    always_comb begin
        pix_ready = 1'b0;
        case (state_q)
            FSTART:  pix_ready = ~(pix_valid & pix_sof);
            FETCH:   pix_ready = pix_valid;
            default: pix_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        line_d     = line_q;
        timer_d    = timer_q;
        lut_raw_d  = lut_raw_q;
        lut_flm_d  = 1'b0;
        lcd_d_d    = lcd_d_q;
        lcd_cp_d   = lcd_cp_q;
        lcd_lp_d   = lcd_lp_q;
        lcd_flm_d  = lcd_flm_q;
        underrun_d = underrun_q;
        sync_err_d = sync_err_q;
        case (state_q)
            IDLE: begin
                underrun_d = 1'b0;
                sync_err_d = 1'b0;
                if (en) begin
                    state_d   = FSTART;
                    lut_flm_d = flm_step;  // high during the first FSTART cycle
                end
            end
            FSTART: begin
                if (pix_valid && pix_sof) begin
                    state_d   = FETCH;
                    line_d    = '0;
                    word_d    = '0;
                    lcd_flm_d = 1'b1;
                end
            end
            FETCH: begin
                lcd_cp_d = 1'b0;
                if (pix_valid) begin
                    lut_raw_d = pix_data;
                    state_d   = SHIFT;
                    if (pix_sof && (line_q != '0 || word_q != '0))
                        sync_err_d = 1'b1;
                end else if (line_q != '0 || word_q != '0) begin
                    underrun_d = 1'b1;
                end
            end
            SHIFT: begin
                // The LUT has had a full cycle to settle on lut_raw_q.
                lcd_d_d  = shift_bits;
                lcd_cp_d = 1'b1;
                if (word_q == WORD_LAST) begin
                    state_d = TAIL;
                end else begin
                    word_d  = word_q + WW'(1);
                    state_d = FETCH;
                end
            end
            TAIL: begin
                lcd_cp_d = 1'b0;
                lcd_lp_d = 1'b1;
                timer_d  = '0;
                state_d  = LP;
            end
            LP: begin
                if (timer_q == LP_LAST) begin
                    lcd_lp_d = 1'b0;
                    timer_d  = '0;
                    state_d  = HB;
                    if (line_q == '0)
                        lcd_flm_d = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HB: begin
                if (timer_q == HB_LAST) begin
                    timer_d = '0;
                    if (!en) begin
                        state_d = IDLE;
                        lcd_d_d = '0;
                    end else if (line_q == LINE_LAST) begin
                        state_d   = FSTART;
                        lut_flm_d = flm_step;
                    end else begin
                        line_d  = line_q + LW'(1);
                        word_d  = '0;
                        state_d = FETCH;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            line_q     <= '0;
            timer_q    <= '0;
            lut_raw_q  <= '0;
            lut_flm_q  <= 1'b0;
            lcd_d_q    <= '0;
            lcd_cp_q   <= 1'b0;
            lcd_lp_q   <= 1'b0;
            lcd_flm_q  <= 1'b0;
            underrun_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            line_q     <= line_d;
            timer_q    <= timer_d;
            lut_raw_q  <= lut_raw_d;
            lut_flm_q  <= lut_flm_d;
            lcd_d_q    <= lcd_d_d;
            lcd_cp_q   <= lcd_cp_d;
            lcd_lp_q   <= lcd_lp_d;
            lcd_flm_q  <= lcd_flm_d;
            underrun_q <= underrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign lut_raw  = lut_raw_q;
    assign lut_flm  = lut_flm_q;
    assign lcd_d    = lcd_d_q;
    assign lcd_cp   = lcd_cp_q;
    assign lcd_lp   = lcd_lp_q;
    assign lcd_flm  = lcd_flm_q;
    assign underrun = underrun_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_stn_scan_ctrl.sv
// Testbench for stn_scan_ctrl. It drives a randomized fetch stream and
// checks the panel-side behaviour with a negedge monitor and a scoreboard.
module tb_stn_scan_ctrl;
    localparam int H        = 8;
    localparam int V        = 2;
    localparam int BW       = 4;
    localparam int LPC      = 2;
    localparam int HBC      = 1;
    localparam int W        = H / BW;                 // words per line
    localparam int NW       = W * V;                  // words per frame
    localparam int LINE_LEN = 2 * W + 1 + LPC + HBC;  // unstalled line

    typedef logic [5*BW-1:0] word_t;

    logic          clk = 1'b0;
    logic          rst, en, pix_valid, pix_ready, pix_sof;
    word_t         pix_data, lut_raw;
    logic          lut_flm, lcd_cp, lcd_lp, lcd_flm, underrun, sync_err;
    logic [BW-1:0] dither_in, lcd_d;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] exp_q[$];   // expected lcd_d per CP falling edge
    logic [BW-1:0] seen_q[$];  // lcd_d values actually shown
    int            gap_log[$]; // CP low run between pulses of the same line
    bit            chk_len = 1'b0;
    int            flm_pulses = 0;

    stn_scan_ctrl #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .BUS_WIDTH(BW),
        .LP_CYCLES(LPC),
        .HB_CYCLES(HBC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_sof  (pix_sof),
        .pix_data (pix_data),
        .lut_raw  (lut_raw),
        .lut_flm  (lut_flm),
        .dither_in(dither_in),
        .lcd_d    (lcd_d),
        .lcd_cp   (lcd_cp),
        .lcd_lp   (lcd_lp),
        .lcd_flm  (lcd_flm),
        .underrun (underrun),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    // LUT stand-in: each lane's dither output is the LSB of its grey value.
    always_comb begin
        dither_in = '0;
        for (int i = 0; i < BW; i++) dither_in[i] = lut_raw[5*i];
    end

    // Reference: pixel p of a word (p=0 leftmost, at [4:0]) must appear on
    // panel bit BW-1-p, carrying that pixel's grey LSB.
    function automatic logic [BW-1:0] pixels_out(input word_t d);
        logic [BW-1:0] r;
        r = '0;
        for (int p = 0; p < BW; p++) r[BW-1-p] = d[5*p];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic cp_prev = 1'b0, lp_prev = 1'b0, lf_prev = 1'b0;
    int   cp_low = 0, cp_in_line = 0, lp_w = 0, lf_w = 0;
    int   line_idx = 0, cyc = 0, last_lp = -1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            cp_prev = 1'b0; lp_prev = 1'b0; lf_prev = 1'b0;
            cp_low = 0; cp_in_line = 0; lp_w = 0; lf_w = 0;
            line_idx = 0; last_lp = -1;
        end else begin
            if (cp_prev && !lcd_cp) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cp_fall_unexpected: lcd_d=%0h with no word pending", lcd_d);
                end else begin
                    chk("lcd_d_at_cp_fall", 64'(lcd_d), 64'(exp_q.pop_front()));
                    seen_q.push_back(lcd_d);
                end
            end
            if (!cp_prev && lcd_cp) begin
                if (cp_in_line > 0) gap_log.push_back(cp_low);
                cp_in_line++;
            end
            cp_low = lcd_cp ? 0 : cp_low + 1;

            if (lut_flm) begin
                lf_w++;
                line_idx = 0;
                last_lp  = -1;
            end else if (lf_prev) begin
                chk("lut_flm_width", 64'(lf_w), 64'(1));
                lf_w = 0;
                flm_pulses++;
            end

            if (lcd_lp && !lp_prev) begin
                chk("cp_per_line", 64'(cp_in_line), 64'(W));
                cp_in_line = 0;
                chk("lcd_flm_in_lp", 64'(lcd_flm), 64'(line_idx == 0));
                if (chk_len && last_lp >= 0)
                    chk("line_len", 64'(cyc - last_lp), 64'(LINE_LEN));
                last_lp = cyc;
            end
            if (lcd_lp) begin
                lp_w++;
            end else if (lp_prev) begin
                chk("lp_width", 64'(lp_w), 64'(LPC));
                chk("lcd_flm_after_lp", 64'(lcd_flm), 64'(0));
                lp_w = 0;
                line_idx++;
            end
            cp_prev = lcd_cp; lp_prev = lcd_lp; lf_prev = lut_flm;
        end
    end

    // ---------------- driver ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
        end
    endtask

    task automatic put_word(input word_t d, input logic s, input bit is_data);
        int budget;
        bit done;
        budget = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = d;
            pix_sof   = s;
            #1;
            if (pix_ready) begin
                if (is_data) exp_q.push_back(pixels_out(d));
                @(posedge clk);
                done = 1'b1;
            end else if (++budget >= 400) begin
                checks++; errors++;
                $display("FAIL handshake_timeout: word not taken after %0d cycles", budget);
                done = 1'b1;
            end
        end
    endtask

    // rst_after >= 0: assert reset one negedge after that word's handshake,
    // i.e. while the word is in its SHIFT cycle.
    task automatic send_frame(input int junk, input int sof_extra, input int stall_idx,
                              input int stall_len, input bit rnd_gaps,
                              input bit first_fixed, input int rst_after);
        word_t d;
        for (int j = 0; j < junk; j++) put_word('0, 1'b0, 1'b0);
        for (int k = 0; k < NW; k++) begin
            if (k == stall_idx) idle_cycles(stall_len);
            else if (rnd_gaps && k > 0) idle_cycles(int'($urandom_range(0, 2)));
            d = word_t'($urandom);
            if (k == 0 && first_fixed) d = {5'd0, 5'd31, 5'd0, 5'd31};
            put_word(d, (k == 0) || (k == sof_extra), 1'b1);
            if (k == rst_after) begin
                @(negedge clk);
                rst = 1'b1;
                en  = 1'b0;
                exp_q.delete();
                return;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d words never shown, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_ready"}, 64'(pix_ready), 64'(0));
        chk({tag, "_lut_raw"},   64'(lut_raw),   64'(0));
        chk({tag, "_lut_flm"},   64'(lut_flm),   64'(0));
        chk({tag, "_lcd_d"},     64'(lcd_d),     64'(0));
        chk({tag, "_lcd_cp"},    64'(lcd_cp),    64'(0));
        chk({tag, "_lcd_lp"},    64'(lcd_lp),    64'(0));
        chk({tag, "_lcd_flm"},   64'(lcd_flm),   64'(0));
        chk({tag, "_underrun"},  64'(underrun),  64'(0));
        chk({tag, "_sync_err"},  64'(sync_err),  64'(0));
    endtask

    int flm_snap;

    initial begin
        rst = 1'b1; en = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // Frame A: three junk words before sof, clean stream, line length.
        chk_len = 1'b1;
        seen_q.delete();
        en = 1'b1;
        send_frame(3, -1, -1, 0, 1'b0, 1'b1, -1);
        drain();
        chk_len = 1'b0;
        if (seen_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL first_lcd_d: nothing shown, expected 1010");
        end else begin
            chk("first_lcd_d", 64'(seen_q[0]), 64'(4'b1010));
        end
        chk("sync_err_after_junk", 64'(sync_err), 64'(0));
        chk("underrun_clean", 64'(underrun), 64'(0));

        // Frame B: 5-cycle stall at line 0 word 1.
        gap_log.delete();
        send_frame(0, -1, 1, 6, 1'b0, 1'b0, -1);
        drain();
        chk("gap_log_size", 64'(gap_log.size()), 64'(2));
        if (gap_log.size() == 2) begin
            chk("cp_low_stalled", 64'(gap_log[0]), 64'(1 + 5));
            chk("cp_low_normal", 64'(gap_log[1]), 64'(1));
        end
        chk("underrun_set", 64'(underrun), 64'(1));

        // Frame C: stray sof at line 1 word 0; frame D must resync.
        send_frame(0, W, -1, 0, 1'b0, 1'b0, -1);
        drain();
        chk("sync_err_set", 64'(sync_err), 64'(1));
        chk_len = 1'b1;
        send_frame(0, -1, -1, 0, 1'b0, 1'b0, -1);
        drain();
        chk_len = 1'b0;
        chk("sync_err_sticky", 64'(sync_err), 64'(1));
        chk("underrun_sticky", 64'(underrun), 64'(1));

        // Random data with random fetch gaps.
        repeat (3) begin
            send_frame(0, -1, -1, 0, 1'b1, 1'b0, -1);
            drain();
        end

        // Reset during the SHIFT cycle of line 1 word 0.
        send_frame(0, -1, -1, 0, 1'b0, 1'b0, W);
        @(negedge clk);
        check_all_zero("rst_mid_line");
        rst = 1'b0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("idle_after_rst");

        // Frame F: en drops mid-line; the frame finishes, then IDLE.
        en = 1'b1;
        send_frame(0, -1, -1, 0, 1'b1, 1'b0, -1);
        en = 1'b0;
        drain();
        chk("lcd_d_cleared_idle", 64'(lcd_d), 64'(0));
        flm_snap = flm_pulses;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_sof = 1'b1;
        #1;
        chk("pix_ready_idle", 64'(pix_ready), 64'(0));
        repeat (20) @(negedge clk);
        chk("no_flm_in_idle", 64'(flm_pulses), 64'(flm_snap));
        pix_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end within 50000 cycles");
        $fatal(1);
    end

endmodule
